// File: rtl/sa_grid_pkg.sv
// sa_grid_pkg: shared types and helpers for the weight-stationary grid.
// Holds the weight-load FSM state, product/sum widths, saturation bounds.
package sa_grid_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_READY
   } st_e;

   function automatic int prod_w(input int dw);
      return 2 * dw;
   endfunction

   // One guard bit above the accumulator to detect signed overflow.
   function automatic int sum_w(input int aw);
      return aw + 1;
   endfunction

   function automatic logic [63:0] sat_hi(input int aw);
      return (64'd1 << (aw - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_lo(input int aw);
      return ~64'd0 << (aw - 1);
   endfunction

endpackage

// File: rtl/sa_pe.sv
// sa_pe: one processing element with stationary weight, east activation
// and south psum registers. Ports: clk_i/rst_i, wt_en_i/wt_i/wt_o (weight
// shift-down chain), en_i (stage valid), act_i/act_o, psum_i/psum_o,
// sat_o when SA_GRID_SAT_EN is defined (saturating add).
module sa_pe
   import sa_grid_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wt_en_i,
   input  logic signed [DW-1:0] wt_i,
   output logic signed [DW-1:0] wt_o,
   input  logic                 en_i,
   input  logic signed [DW-1:0] act_i,
   output logic signed [DW-1:0] act_o,
   input  logic signed [AW-1:0] psum_i,
   output logic signed [AW-1:0] psum_o
`ifdef SA_GRID_SAT_EN
   ,
   output logic                 sat_o
`endif
);

   localparam int PW = prod_w(DW);

   logic signed [DW-1:0] wt_q;
   logic signed [DW-1:0] act_q;
   logic signed [AW-1:0] psum_q;
   logic signed [AW-1:0] psum_d;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_x;

   assign prod   = PW'(act_i) * PW'(wt_q);
   assign prod_x = AW'(prod);

`ifdef SA_GRID_SAT_EN
   localparam int          SW     = sum_w(AW);
   localparam logic [63:0] HI64   = sat_hi(AW);
   localparam logic [63:0] LO64   = sat_lo(AW);
   localparam logic [AW-1:0] SAT_HI = HI64[AW-1:0];
   localparam logic [AW-1:0] SAT_LO = LO64[AW-1:0];

   logic signed [SW-1:0] sum;
   logic                 ovf;

   // Guard bit differing from the sign bit means the add left range.
   always_comb begin
      sum    = SW'(psum_i) + SW'(prod_x);
      ovf    = sum[SW-1] != sum[SW-2];
      psum_d = sum[AW-1:0];
      if (ovf)
         psum_d = sum[SW-1] ? SAT_LO : SAT_HI;
   end

   assign sat_o = en_i & ovf;
`else
   assign psum_d = psum_i + prod_x;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wt_q   <= '0;
         act_q  <= '0;
         psum_q <= '0;
      end else begin
         if (wt_en_i)
            wt_q <= wt_i;
         if (en_i) begin
            act_q  <= act_i;
            psum_q <= psum_d;
         end
      end
   end

   assign wt_o   = wt_q;
   assign act_o  = act_q;
   assign psum_o = psum_q;

endmodule

// File: rtl/sa_grid_ws.sv
// sa_grid_ws: ROWS x COLS weight-stationary systolic MAC grid with input
// skew, output de-skew, valid pipe, weight-load FSM and ready handshakes.
// Ports: i_clk/i_rst, i_wt_valid/i_wt_data/o_wt_ready (weight rows),
// i_valid/i_west_data/i_north_data/o_in_ready (vectors), o_valid/o_data
// (aligned results), o_busy; o_ovf when SA_GRID_SAT_EN is defined.
module sa_grid_ws
   import sa_grid_pkg::*;
#(
   parameter int ROWS = 9,
   parameter int COLS = 4,
   parameter int DW   = 8,
   parameter int AW   = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wt_valid,
   input  logic [COLS*DW-1:0]   i_wt_data,
   output logic                 o_wt_ready,
   input  logic                 i_valid,
   input  logic [ROWS*DW-1:0]   i_west_data,
   input  logic [COLS*AW-1:0]   i_north_data,
   output logic                 o_in_ready,
   output logic                 o_valid,
   output logic [COLS*AW-1:0]   o_data,
   output logic                 o_busy
`ifdef SA_GRID_SAT_EN
   ,
   output logic                 o_ovf
`endif
);

   localparam int L  = ROWS + COLS - 1;
   localparam int CW = $clog2(L + 1);
   localparam int LW = $clog2(ROWS + 1);

   st_e           st_q, st_d;
   logic [LW-1:0] lc_q, lc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [L-1:0]  vp_q, vp_d;
   logic          acc;
   logic          wt_acc;

   logic signed [DW-1:0] wt  [ROWS+1][COLS];
   logic signed [DW-1:0] act [ROWS][COLS+1];
   logic signed [AW-1:0] ps  [ROWS+1][COLS];

   assign acc    = i_valid & o_in_ready;
   assign wt_acc = i_wt_valid & o_wt_ready;

   // vp_d[k] is the enable of every register on anti-diagonal k.
   always_comb begin
      vp_d    = '0;
      vp_d[0] = acc;
      for (int k = 1; k < L; k++)
         vp_d[k] = vp_q[k-1];
   end

   assign o_valid = vp_q[L-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st_q  <= S_IDLE;
         lc_q  <= '0;
         cnt_q <= '0;
         vp_q  <= '0;
      end else begin
         st_q  <= st_d;
         lc_q  <= lc_d;
         cnt_q <= cnt_d;
         vp_q  <= vp_d;
      end
   end

   always_comb begin
      st_d = st_q;
      lc_d = lc_q;
      if (wt_acc) begin
         unique case (st_q)
            S_LOAD: begin
               lc_d = lc_q + 1'b1;
               if (lc_q == LW'(ROWS - 1))
                  st_d = S_READY;
            end
            default: begin
               lc_d = LW'(1);
               st_d = (ROWS == 1) ? S_READY : S_LOAD;
            end
         endcase
      end
   end

   always_comb begin
      o_in_ready = (st_q == S_READY);
      o_wt_ready = (cnt_q == '0) && !i_valid;
      o_busy     = (cnt_q != '0);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (acc && !o_valid)
         cnt_d = cnt_q + 1'b1;
      else if (!acc && o_valid)
         cnt_d = cnt_q - 1'b1;
   end

   for (genvar j = 0; j < COLS; j++) begin : g_wt0
      assign wt[0][j] = i_wt_data[j*DW +: DW];
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_rsk
      if (i == 0) begin : g_d0
         assign act[0][0] = i_west_data[0 +: DW];
      end else begin : g_dn
         logic signed [DW-1:0] sk_q [i];
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int k = 0; k < i; k++)
                  sk_q[k] <= '0;
            end else begin
               if (vp_d[0])
                  sk_q[0] <= i_west_data[i*DW +: DW];
               for (int k = 1; k < i; k++)
                  if (vp_d[k])
                     sk_q[k] <= sk_q[k-1];
            end
         end
         assign act[i][0] = sk_q[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_nsk
      if (j == 0) begin : g_d0
         assign ps[0][0] = i_north_data[0 +: AW];
      end else begin : g_dn
         logic signed [AW-1:0] sk_q [j];
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int k = 0; k < j; k++)
                  sk_q[k] <= '0;
            end else begin
               if (vp_d[0])
                  sk_q[0] <= i_north_data[j*AW +: AW];
               for (int k = 1; k < j; k++)
                  if (vp_d[k])
                     sk_q[k] <= sk_q[k-1];
            end
         end
         assign ps[0][j] = sk_q[j-1];
      end
   end

   // Every stage loads only under its valid, so o_data holds between
   // results without a separate output register.
   for (genvar j = 0; j < COLS; j++) begin : g_dsk
      localparam int D = COLS - 1 - j;
      if (D == 0) begin : g_d0
         assign o_data[j*AW +: AW] = ps[ROWS][j];
      end else begin : g_dn
         logic signed [AW-1:0] dk_q [D];
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int k = 0; k < D; k++)
                  dk_q[k] <= '0;
            end else begin
               if (vp_d[ROWS+j])
                  dk_q[0] <= ps[ROWS][j];
               for (int k = 1; k < D; k++)
                  if (vp_d[ROWS+j+k])
                     dk_q[k] <= dk_q[k-1];
            end
         end
         assign o_data[j*AW +: AW] = dk_q[D-1];
      end
   end

`ifdef SA_GRID_SAT_EN
   logic [ROWS*COLS-1:0] sat;
   logic                 ovf_q;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         ovf_q <= 1'b0;
      else if (|sat)
         ovf_q <= 1'b1;
   end

   assign o_ovf = ovf_q;
`endif

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         sa_pe #(
            .DW (DW),
            .AW (AW)
         ) u_pe (
            .clk_i   (i_clk),
            .rst_i   (i_rst),
            .wt_en_i (wt_acc),
            .wt_i    (wt[i][j]),
            .wt_o    (wt[i+1][j]),
            .en_i    (vp_d[i+j]),
            .act_i   (act[i][j]),
            .act_o   (act[i][j+1]),
            .psum_i  (ps[i][j]),
            .psum_o  (ps[i+1][j])
`ifdef SA_GRID_SAT_EN
            ,
            .sat_o   (sat[i*COLS+j])
`endif
         );
      end
   end

endmodule

// File: tb/tb_sa_grid_ws.sv
// tb_sa_grid_ws: directed self-checking bench for sa_grid_ws, using a
// 2x2 grid at AW=32 and a 2x2 grid at AW=16 for the overflow corner.
module tb_sa_grid_ws;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        wv, iv;
   logic [15:0] wd, xd;
   logic [63:0] nd;
   logic        wr, ir, ov, busy;
   logic [63:0] od;

   logic        wv16, iv16;
   logic [15:0] wd16, xd16;
   logic [31:0] nd16;
   logic        wr16, ir16, ov16, busy16;
   logic [31:0] od16;

`ifdef SA_GRID_SAT_EN
   logic        ovf2, ovf16;
`endif

   int vecs = 0;
   int miss = 0;

   sa_grid_ws #(
      .ROWS (2),
      .COLS (2),
      .DW   (8),
      .AW   (32)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_wt_valid   (wv),
      .i_wt_data    (wd),
      .o_wt_ready   (wr),
      .i_valid      (iv),
      .i_west_data  (xd),
      .i_north_data (nd),
      .o_in_ready   (ir),
      .o_valid      (ov),
      .o_data       (od),
      .o_busy       (busy)
`ifdef SA_GRID_SAT_EN
      ,
      .o_ovf        (ovf2)
`endif
   );

   sa_grid_ws #(
      .ROWS (2),
      .COLS (2),
      .DW   (8),
      .AW   (16)
   ) u_d16 (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_wt_valid   (wv16),
      .i_wt_data    (wd16),
      .o_wt_ready   (wr16),
      .i_valid      (iv16),
      .i_west_data  (xd16),
      .i_north_data (nd16),
      .o_in_ready   (ir16),
      .o_valid      (ov16),
      .o_data       (od16),
      .o_busy       (busy16)
`ifdef SA_GRID_SAT_EN
      ,
      .o_ovf        (ovf16)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst  = 1'b1;
      wv   = 1'b0; iv   = 1'b0; wd   = '0; xd   = '0; nd   = '0;
      wv16 = 1'b0; iv16 = 1'b0; wd16 = '0; xd16 = '0; nd16 = '0;
      tick();
      tick();
      chk("rst_valid", 32'(ov), 0);
      chk("rst_c0", od[31:0], 0);
      chk("rst_c1", od[63:32], 0);
      chk("rst_in_rdy", 32'(ir), 0);
      chk("rst_wt_rdy", 32'(wr), 1);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;

      // vectors offered with no weights loaded are dropped
      iv = 1'b1; xd = {8'd6, 8'd5};
      #1;
      chk("idle_wt_rdy", 32'(wr), 0);
      chk("idle_in_rdy", 32'(ir), 0);
      tick();
      tick();
      iv = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("idle_no_valid", 32'(ov), 0);
         chk("idle_busy", 32'(busy), 0);
      end

      // two-beat load: row1=(1,2), row0=(3,4)
      wv = 1'b1; wd = {8'd2, 8'd1};
      tick();
      chk("load1_in_rdy", 32'(ir), 0);
      wd = {8'd4, 8'd3};
      tick();
      wv = 1'b0;
      chk("load2_in_rdy", 32'(ir), 1);

      // single vector, latency 3
      iv = 1'b1; xd = {8'd6, 8'd5}; nd = '0;
      tick();
      iv = 1'b0;
      chk("a_lat1", 32'(ov), 0);
      chk("a_busy", 32'(busy), 1);
      tick();
      chk("a_lat2", 32'(ov), 0);
      tick();
      chk("a_valid", 32'(ov), 1);
      chk("a_c0", od[31:0], 21);
      chk("a_c1", od[63:32], 32);
      tick();
      chk("a_after", 32'(ov), 0);
      chk("a_idle", 32'(busy), 0);

      // A, bubble, B
      iv = 1'b1; xd = {8'd6, 8'd5}; nd = '0;
      tick();
      iv = 1'b0;
      chk("bb_v0", 32'(ov), 0);
      tick();
      iv = 1'b1; xd = {8'd2, 8'hFF}; nd = {32'hFFFF_FFF9, 32'd100};
      chk("bb_v1", 32'(ov), 0);
      tick();
      iv = 1'b0;
      chk("bb_v2", 32'(ov), 1);
      chk("bb_a_c0", od[31:0], 21);
      chk("bb_a_c1", od[63:32], 32);
      tick();
      chk("bb_v3", 32'(ov), 0);
      chk("bb_hold_c0", od[31:0], 21);
      chk("bb_hold_c1", od[63:32], 32);
      tick();
      chk("bb_v4", 32'(ov), 1);
      chk("bb_b_c0", od[31:0], 99);
      chk("bb_b_c1", od[63:32], 32'hFFFF_FFF9);
      tick();
      chk("bb_v5", 32'(ov), 0);
      chk("bb_idle", 32'(busy), 0);

      // weight beat held off while data is in flight
      iv = 1'b1; xd = {8'd6, 8'd5}; nd = '0;
      wv = 1'b1; wd = {8'd9, 8'd9};
      #1;
      chk("wb_rdy_iv", 32'(wr), 0);
      tick();
      iv = 1'b0;
      chk("wb_rdy_f1", 32'(wr), 0);
      tick();
      chk("wb_rdy_f2", 32'(wr), 0);
      tick();
      chk("wb_valid", 32'(ov), 1);
      chk("wb_c0", od[31:0], 21);
      chk("wb_c1", od[63:32], 32);
      chk("wb_rdy_out", 32'(wr), 0);
      tick();
      chk("wb_rdy_free", 32'(wr), 1);
      tick();
      wv = 1'b0;
      chk("wb_load_state", 32'(ir), 0);

      // vector in LOAD is dropped
      iv = 1'b1; xd = {8'd1, 8'd1};
      tick();
      iv = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("load_drop", 32'(ov), 0);
      end
      chk("load_drop_busy", 32'(busy), 0);

      // second beat: row0=(1,2), row1=(9,9)
      wv = 1'b1; wd = {8'd2, 8'd1};
      tick();
      wv = 1'b0;
      chk("reload_ready", 32'(ir), 1);
      iv = 1'b1; xd = {8'd1, 8'd1}; nd = '0;
      tick();
      iv = 1'b0;
      tick();
      tick();
      chk("c_valid", 32'(ov), 1);
      chk("c_c0", od[31:0], 10);
      chk("c_c1", od[63:32], 11);
      tick();

      // reset with two vectors in flight
      iv = 1'b1; xd = {8'd1, 8'd1};
      tick();
      tick();
      iv  = 1'b0;
      rst = 1'b1;
      chk("mr_busy_pre", 32'(busy), 1);
      tick();
      rst = 1'b0;
      chk("mr_valid", 32'(ov), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_idle", 32'(ir), 0);
      chk("mr_c0", od[31:0], 0);
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("mr_no_valid", 32'(ov), 0);
      end

      // AW=16 overflow corner
      wv16 = 1'b1; wd16 = {8'd1, 8'd1};
      tick();
      tick();
      wv16 = 1'b0;
      chk("s_ready", 32'(ir16), 1);
      iv16 = 1'b1; xd16 = {8'd0, 8'd1}; nd16 = {16'd0, 16'h7FFF};
      tick();
      iv16 = 1'b0;
      tick();
      tick();
      chk("s_valid", 32'(ov16), 1);
`ifdef SA_GRID_SAT_EN
      chk("s_c0", {16'd0, od16[15:0]}, 32'h7FFF);
`else
      chk("s_c0", {16'd0, od16[15:0]}, 32'h8000);
`endif
      chk("s_c1", {16'd0, od16[31:16]}, 1);
      tick();
      chk("s_busy", 32'(busy16), 0);
      chk("s_wt_rdy", 32'(wr16), 1);
`ifdef SA_GRID_SAT_EN
      chk("s_ovf", 32'(ovf16), 1);
      tick();
      tick();
      chk("s_ovf_held", 32'(ovf16), 1);
      chk("s_ovf_other", 32'(ovf2), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s_ovf_clr", 32'(ovf16), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
